// File: rtl/jtag_tap_target_if.sv
// Pin bundle for the JTAG TAP responder: JTAG pins, TAP status and the
// fabric-side user data register strobes. The master side drives the JTAG
// pins and the capture data; the slave side is the TAP itself.
interface jtag_tap_target_if #(
    parameter int unsigned IR_LEN   = 4,
    parameter int unsigned USER_LEN = 32
);
    logic                TCK;
    logic                TMS;
    logic                TDI;
    logic                TDO;
    logic                TDO_OE;
    logic [3:0]          STATE;
    logic [IR_LEN-1:0]   IR;
    logic                USER_CAPTURE;
    logic [USER_LEN-1:0] USER_CAPTURE_DATA;
    logic                USER_UPDATE;
    logic [USER_LEN-1:0] USER_UPDATE_DATA;

    modport master (
        output TCK, TMS, TDI, USER_CAPTURE_DATA,
        input  TDO, TDO_OE, STATE, IR, USER_CAPTURE, USER_UPDATE, USER_UPDATE_DATA
    );

    modport slave (
        input  TCK, TMS, TDI, USER_CAPTURE_DATA,
        output TDO, TDO_OE, STATE, IR, USER_CAPTURE, USER_UPDATE, USER_UPDATE_DATA
    );
endinterface

// File: rtl/jtag_tap_target.sv
// Oversampled JTAG TAP responder. TCK/TMS/TDI are recovered in the CLK domain,
// the 16-state TAP controller advances on recovered TCK rises, and the
// IR / BYPASS / IDCODE / USER data registers are served from one DR shifter.
// Optional feature macro: JTAG_TAP_IDCODE_EN (IDCODE register present and
// selected after reset; otherwise IR_IDCODE decodes as BYPASS).
module jtag_tap_target #(
    parameter int unsigned       IR_LEN     = 4,
    parameter int unsigned       USER_LEN   = 32,
    parameter logic [31:0]       IDCODE_VAL = 32'h1BA01477,
    parameter logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(4'hE),
    parameter logic [IR_LEN-1:0] IR_USER    = IR_LEN'(4'hA)
) (
    input logic               CLK,
    input logic               RESET,
    jtag_tap_target_if.slave  tap
);

`ifdef JTAG_TAP_IDCODE_EN
    localparam int unsigned       DR_MAX   = (USER_LEN > 32) ? USER_LEN : 32;
    localparam int unsigned       SR_LEN   = (IR_LEN > DR_MAX) ? IR_LEN : DR_MAX;
    localparam logic [IR_LEN-1:0] IR_RESET = IR_IDCODE;
`else
    localparam int unsigned       SR_LEN   = (IR_LEN > USER_LEN) ? IR_LEN : USER_LEN;
    localparam logic [IR_LEN-1:0] IR_RESET = '1;
`endif

    // Reject parameter sets the TAP cannot honour (IDCODE must have bit0 set).
    if (IR_LEN < 2 || USER_LEN < 1 || IDCODE_VAL[0] != 1'b1 || IR_IDCODE == IR_USER) begin : g_bad_cfg
        $error("jtag_tap_target: invalid parameterisation");
    end

    typedef enum logic [3:0] {
        RUNTEST_IDLE = 4'b0000,
        SELECT_DR    = 4'b0001,
        SHIFT_DR     = 4'b0010,
        UPDATE_DR    = 4'b0011,
        CAPTURE_DR   = 4'b0100,
        EXIT1_DR     = 4'b0101,
        PAUSE_DR     = 4'b0110,
        EXIT2_DR     = 4'b0111,
        LOGIC_RESET  = 4'b1000,
        SELECT_IR    = 4'b1001,
        SHIFT_IR     = 4'b1010,
        UPDATE_IR    = 4'b1011,
        CAPTURE_IR   = 4'b1100,
        EXIT1_IR     = 4'b1101,
        PAUSE_IR     = 4'b1110,
        EXIT2_IR     = 4'b1111
    } tap_state_e;

    logic                tck_s1_q, tck_s2_q, tck_s3_q;
    logic                tms_s1_q, tms_s2_q;
    logic                tdi_s1_q, tdi_s2_q;
    logic                tck_r, tck_f;

    tap_state_e          state_q, state_d;
    logic [IR_LEN-1:0]   ir_sr_q, ir_sr_d;
    logic [IR_LEN-1:0]   ir_q, ir_d;
    logic [SR_LEN-1:0]   sr_q, sr_d;
    logic                tdo_q, tdo_d;
    logic                upd_pulse_q, upd_pulse_d;
    logic [USER_LEN-1:0] upd_data_q, upd_data_d;
    logic                user_capture;
    logic                is_user;
    logic                is_idcode;

    // TMS/TDI are taken from the same stage as TCK so they line up with the strobes.
    assign tck_r = tck_s2_q & ~tck_s3_q;
    assign tck_f = ~tck_s2_q & tck_s3_q;

    assign is_user = (ir_q == IR_USER);
`ifdef JTAG_TAP_IDCODE_EN
    assign is_idcode = (ir_q == IR_IDCODE);
`else
    assign is_idcode = 1'b0;
`endif

    // Two-flop synchronizers for the JTAG pins plus TCK edge history.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tck_s1_q <= 1'b0;
            tck_s2_q <= 1'b0;
            tck_s3_q <= 1'b0;
            tms_s1_q <= 1'b0;
            tms_s2_q <= 1'b0;
            tdi_s1_q <= 1'b0;
            tdi_s2_q <= 1'b0;
        end else begin
            tck_s1_q <= tap.TCK;
            tck_s2_q <= tck_s1_q;
            tck_s3_q <= tck_s2_q;
            tms_s1_q <= tap.TMS;
            tms_s2_q <= tms_s1_q;
            tdi_s1_q <= tap.TDI;
            tdi_s2_q <= tdi_s1_q;
        end
    end

    // TAP controller state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // IEEE 1149.1 next-state decode, advanced only on a recovered TCK rise.
    always_comb begin
        state_d = state_q;
        if (tck_r) begin
            case (state_q)
                LOGIC_RESET:  state_d = tms_s2_q ? LOGIC_RESET : RUNTEST_IDLE;
                RUNTEST_IDLE: state_d = tms_s2_q ? SELECT_DR   : RUNTEST_IDLE;
                SELECT_DR:    state_d = tms_s2_q ? SELECT_IR   : CAPTURE_DR;
                CAPTURE_DR:   state_d = tms_s2_q ? EXIT1_DR    : SHIFT_DR;
                SHIFT_DR:     state_d = tms_s2_q ? EXIT1_DR    : SHIFT_DR;
                EXIT1_DR:     state_d = tms_s2_q ? UPDATE_DR   : PAUSE_DR;
                PAUSE_DR:     state_d = tms_s2_q ? EXIT2_DR    : PAUSE_DR;
                EXIT2_DR:     state_d = tms_s2_q ? UPDATE_DR   : SHIFT_DR;
                UPDATE_DR:    state_d = tms_s2_q ? SELECT_DR   : RUNTEST_IDLE;
                SELECT_IR:    state_d = tms_s2_q ? LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:   state_d = tms_s2_q ? EXIT1_IR    : SHIFT_IR;
                SHIFT_IR:     state_d = tms_s2_q ? EXIT1_IR    : SHIFT_IR;
                EXIT1_IR:     state_d = tms_s2_q ? UPDATE_IR   : PAUSE_IR;
                PAUSE_IR:     state_d = tms_s2_q ? EXIT2_IR    : PAUSE_IR;
                EXIT2_IR:     state_d = tms_s2_q ? UPDATE_IR   : SHIFT_IR;
                UPDATE_IR:    state_d = tms_s2_q ? SELECT_DR   : RUNTEST_IDLE;
                default:      state_d = LOGIC_RESET;
            endcase
        end
    end

    // Shift/capture on TCK rise (in the pre-transition state); TDO and
    // update actions on TCK fall, by which time the state has already moved.
    always_comb begin
        ir_sr_d      = ir_sr_q;
        sr_d         = sr_q;
        ir_d         = ir_q;
        tdo_d        = tdo_q;
        upd_data_d   = upd_data_q;
        upd_pulse_d  = 1'b0;
        user_capture = 1'b0;

        if (tck_r) begin
            case (state_q)
                CAPTURE_IR: ir_sr_d = IR_LEN'(1);
                SHIFT_IR:   ir_sr_d = {tdi_s2_q, ir_sr_q[IR_LEN-1:1]};
                CAPTURE_DR: begin
                    if (is_idcode) begin
                        sr_d = SR_LEN'(IDCODE_VAL);
                    end else if (is_user) begin
                        sr_d         = SR_LEN'(tap.USER_CAPTURE_DATA);
                        user_capture = 1'b1;
                    end else begin
                        sr_d = '0;
                    end
                end
                SHIFT_DR: begin
                    sr_d = sr_q >> 1;
                    if (is_user) begin
                        sr_d[USER_LEN-1] = tdi_s2_q;
`ifdef JTAG_TAP_IDCODE_EN
                    end else if (is_idcode) begin
                        sr_d[31] = tdi_s2_q;
`endif
                    end else begin
                        sr_d[0] = tdi_s2_q;
                    end
                end
                default: ;
            endcase
        end

        if (tck_f) begin
            tdo_d = 1'b0;
            case (state_q)
                SHIFT_IR:    tdo_d = ir_sr_q[0];
                SHIFT_DR:    tdo_d = sr_q[0];
                UPDATE_IR:   ir_d  = ir_sr_q;
                UPDATE_DR: begin
                    if (is_user) begin
                        upd_data_d  = sr_q[USER_LEN-1:0];
                        upd_pulse_d = 1'b1;
                    end
                end
                LOGIC_RESET: ir_d = IR_RESET;
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ir_sr_q     <= '0;
            sr_q        <= '0;
            ir_q        <= IR_RESET;
            tdo_q       <= 1'b0;
            upd_pulse_q <= 1'b0;
            upd_data_q  <= '0;
        end else begin
            ir_sr_q     <= ir_sr_d;
            sr_q        <= sr_d;
            ir_q        <= ir_d;
            tdo_q       <= tdo_d;
            upd_pulse_q <= upd_pulse_d;
            upd_data_q  <= upd_data_d;
        end
    end

    assign tap.TDO              = tdo_q;
    assign tap.TDO_OE           = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
    assign tap.STATE            = state_q;
    assign tap.IR               = ir_q;
    assign tap.USER_CAPTURE     = user_capture;
    assign tap.USER_UPDATE      = upd_pulse_q;
    assign tap.USER_UPDATE_DATA = upd_data_q;

endmodule

// File: tb/tb_jtag_tap_target.sv
// Bench for jtag_tap_target: directed and random IR/DR scans driven at the
// JTAG pins. Every data register is modelled as a FIFO of its length that
// starts holding the captured bits; TDO expectations, update values and
// strobe counts are derived from that FIFO and checked by separate monitors.
module tb_jtag_tap_target;
    localparam int unsigned IR_LEN   = 4;
    localparam int unsigned USER_LEN = 32;
    localparam logic [31:0] IDCODE   = 32'h1BA01477;
    localparam logic [3:0]  IR_IDC   = 4'hE;
    localparam logic [3:0]  IR_USR   = 4'hA;
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [3:0]  IR_RST   = 4'hE;
    localparam bit          HAS_IDC  = 1'b1;
`else
    localparam logic [3:0]  IR_RST   = 4'hF;
    localparam bit          HAS_IDC  = 1'b0;
`endif
    localparam int HALF = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtag_tap_target_if #(.IR_LEN(IR_LEN), .USER_LEN(USER_LEN)) tap();

    jtag_tap_target #(
        .IR_LEN    (IR_LEN),
        .USER_LEN  (USER_LEN),
        .IDCODE_VAL(IDCODE),
        .IR_IDCODE (IR_IDC),
        .IR_USER   (IR_USR)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .tap  (tap)
    );

    int n_vec = 0;
    int n_err = 0;
    int cap_seen = 0;
    int upd_seen = 0;
    int exp_cap = 0;
    int exp_upd = 0;

    bit          exp_tdo[$];
    logic [31:0] exp_upd_q[$];
    bit          fifo[$];
    logic [3:0]  m_ir;
    logic [31:0] m_user;
    logic [31:0] cap_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fifo_value();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < fifo.size() && i < 32; i++) v[i] = fifo[i];
        return v;
    endfunction

    // One full TCK period; TMS/TDI change while TCK is low.
    task automatic tck(input logic tms, input logic tdi);
        tap.TMS = tms;
        tap.TDI = tdi;
        #HALF tap.TCK = 1'b1;
        #HALF tap.TCK = 1'b0;
    endtask

    task automatic shift_bits(input int unsigned n, input logic [63:0] bits, input bit exit_last);
        for (int unsigned i = 0; i < n; i++) begin
            logic b;
            b = bits[i];
            exp_tdo.push_back(fifo.pop_front());
            fifo.push_back(b);
            tck(exit_last && (i == n - 1), b);
        end
    endtask

    // IDLE -> SHIFT_DR, loading the model FIFO with what CAPTURE_DR should grab.
    task automatic dr_enter();
        logic [31:0] cap;
        int unsigned len;
        if (HAS_IDC && m_ir == IR_IDC) begin
            len = 32; cap = IDCODE;
        end else if (m_ir == IR_USR) begin
            len = USER_LEN; cap = cap_data; exp_cap++;
        end else begin
            len = 1; cap = '0;
        end
        fifo.delete();
        for (int unsigned i = 0; i < len; i++) fifo.push_back(cap[i]);
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        tck(1'b0, 1'b0);
    endtask

    task automatic dr_scan(input int unsigned n, input logic [63:0] bits);
        dr_enter();
        shift_bits(n, bits, 1'b1);
        check("dr_exit1_state", tap.STATE, 4'b0101);
        if (m_ir == IR_USR) begin
            m_user = fifo_value();
            exp_upd_q.push_back(m_user);
            exp_upd++;
        end
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        #HALF;
        check("user_update_data_held", tap.USER_UPDATE_DATA, m_user);
        check("capture_count", cap_seen, exp_cap);
        check("update_count", upd_seen, exp_upd);
    endtask

    task automatic ir_scan(input logic [3:0] val);
        tck(1'b1, 1'b0);
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        tck(1'b0, 1'b0);
        fifo.delete();
        for (int unsigned i = 0; i < IR_LEN; i++) fifo.push_back(i == 0);
        shift_bits(IR_LEN, {60'd0, val}, 1'b1);
        check("ir_exit1_state", tap.STATE, 4'b1101);
        m_ir = fifo_value()[3:0];
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        #HALF;
        check("ir_after_update", tap.IR, m_ir);
    endtask

    // TDO monitor: at every TCK rise, shift states must present the next FIFO bit.
    initial begin
        forever begin
            @(posedge tap.TCK);
            if (tap.TDO_OE === 1'b1) begin
                if (exp_tdo.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL tdo_unexpected_shift: got TDO_OE=1, want no shift");
                end else begin
                    check("tdo_bit", tap.TDO, exp_tdo.pop_front());
                end
            end else begin
                check("tdo_idle", tap.TDO, 32'd0);
            end
        end
    end

    // Strobe monitor: count capture pulses, match update pulses to the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (tap.USER_CAPTURE === 1'b1) cap_seen++;
            if (tap.USER_UPDATE === 1'b1) begin
                upd_seen++;
                if (exp_upd_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL user_update_unexpected: got pulse with data %h, want none",
                             tap.USER_UPDATE_DATA);
                end else begin
                    check("user_update_data", tap.USER_UPDATE_DATA, exp_upd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] instr;
        tap.TCK = 1'b0;
        tap.TMS = 1'b0;
        tap.TDI = 1'b0;
        cap_data = '0;
        tap.USER_CAPTURE_DATA = '0;
        m_ir   = IR_RST;
        m_user = '0;

        #30 rst = 1'b0;
        #10;
        check("reset_state", tap.STATE, 4'b1000);
        check("reset_ir", tap.IR, IR_RST);
        check("reset_tdo_oe", tap.TDO_OE, 32'd0);
        check("reset_tdo", tap.TDO, 32'd0);
        check("reset_user_data", tap.USER_UPDATE_DATA, 32'd0);
        check("reset_user_update", tap.USER_UPDATE, 32'd0);

        // TMS 0 then DR scan: IDCODE streams out (BYPASS when IDCODE absent).
        tck(1'b0, 1'b0);
        dr_scan(32, {$urandom, $urandom});

        ir_scan(4'hA);
        check("ir_user_directed", tap.IR, 32'hA);

        cap_data = 32'hDEADBEEF;
        tap.USER_CAPTURE_DATA = cap_data;
        dr_scan(32, 64'h12345678);
        check("user_data_directed", tap.USER_UPDATE_DATA, 32'h12345678);

        ir_scan(4'h3);
        dr_scan(8, 64'hA5);

        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0:       instr = IR_IDC;
                1:       instr = IR_USR;
                default: instr = 4'($urandom);
            endcase
            ir_scan(instr);
            cap_data = $urandom;
            tap.USER_CAPTURE_DATA = cap_data;
            dr_scan($urandom_range(1, 40), {$urandom, $urandom});
        end

        // Mid-scan TMS reset: five TMS=1 rises from SHIFT_DR.
        ir_scan(4'h3);
        dr_enter();
        shift_bits(5, {$urandom, $urandom}, 1'b1);
        repeat (4) tck(1'b1, 1'b0);
        check("tms_reset_state", tap.STATE, 4'b1000);
        #HALF;
        m_ir = IR_RST;
        check("tms_reset_ir", tap.IR, m_ir);
        check("tms_reset_no_update", upd_seen, exp_upd);
        check("tms_reset_user_data", tap.USER_UPDATE_DATA, m_user);
        tck(1'b0, 1'b0);

        // Mid-scan RESET under the USER instruction.
        ir_scan(4'hA);
        cap_data = $urandom;
        tap.USER_CAPTURE_DATA = cap_data;
        dr_enter();
        shift_bits(5, {$urandom, $urandom}, 1'b0);
        rst = 1'b1;
        #10 rst = 1'b0;
        #10;
        m_ir   = IR_RST;
        m_user = '0;
        check("rst_mid_state", tap.STATE, 4'b1000);
        check("rst_mid_ir", tap.IR, m_ir);
        check("rst_mid_user_data", tap.USER_UPDATE_DATA, m_user);
        check("rst_mid_tdo_oe", tap.TDO_OE, 32'd0);
        check("rst_mid_tdo", tap.TDO, 32'd0);
        check("rst_mid_capture_count", cap_seen, exp_cap);
        check("rst_mid_no_update", upd_seen, exp_upd);

        // Recovery after reset.
        tck(1'b0, 1'b0);
        ir_scan(4'hA);
        cap_data = $urandom;
        tap.USER_CAPTURE_DATA = cap_data;
        dr_scan(32, {$urandom, $urandom});

        #(4 * HALF);
        check("tdo_expect_drained", exp_tdo.size(), 32'd0);
        check("update_expect_drained", exp_upd_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
